// File: rtl/cpu_trace_tx.sv
// cpu_trace_tx: captures retired-instruction samples at the execute strobe,
// packs them into 4-byte records, buffers them in a small FIFO and streams
// them out one byte at a time over a valid/ready link to a host receiver.
module cpu_trace_tx #(
  parameter int          DEPTH    = 4,
  parameter logic [3:0]  SYNC_NIB = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trace_en,
  input  logic        exec_valid,
  input  logic [15:0] raw_instruction,
  input  logic [3:0]  result,
  input  logic [3:0]  nzvc,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

  // Record layout: {seq[3:0], instr[15:0], nzvc[3:0], result[3:0]}
  logic [27:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    seq;

  state_t        state;
  logic [27:0]   sreg;

  logic          capture;
  logic          hs;
  logic          pop;
  logic          push;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [27:0]   head;
  logic [27:0]   new_rec;

  // Handshake, pop/push arbitration; a pop in the same cycle frees room for a push
  always_comb begin
    fifo_full  = (count == (AW+1)'(DEPTH));
    fifo_empty = (count == '0);
    capture    = trace_en && exec_valid;
    hs         = tx_valid && tx_ready;
    pop        = !fifo_empty && ((state == IDLE) || (state == S3 && hs));
    push       = capture && (!fifo_full || pop);
    drop       = capture && fifo_full && !pop;
    head       = mem[rd_ptr];
    new_rec    = {seq, raw_instruction, nzvc, result};
  end

  // Record storage; contents need no reset since occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  // FIFO pointers, occupancy, sequence number and drop statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (capture) begin
        seq <= seq + 4'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  // Byte serializer: loads a record on pop and walks B0..B3 on each handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sreg     <= head;
            tx_data  <= {SYNC_NIB, head[27:24]};
            tx_valid <= 1'b1;
            state    <= S0;
          end
        end
        S0: begin
          if (hs) begin
            tx_data <= sreg[23:16];
            state   <= S1;
          end
        end
        S1: begin
          if (hs) begin
            tx_data <= sreg[15:8];
            state   <= S2;
          end
        end
        S2: begin
          if (hs) begin
            tx_data <= sreg[7:0];
            state   <= S3;
          end
        end
        S3: begin
          if (hs) begin
            if (pop) begin
              sreg     <= head;
              tx_data  <= {SYNC_NIB, head[27:24]};
              tx_valid <= 1'b1;
              state    <= S0;
            end else begin
              tx_data  <= '0;
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Busy whenever a record is buffered or being sent; both sources are registers
  always_comb begin
    busy = !fifo_empty || (state != IDLE);
  end

endmodule
